rgb_source_gen: RTL

RGB_SOURCE_GEN -- requirements
Module: rgb_source_gen

---
 rtl/rgb_source_gen.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rgb_source_gen.sv
// rgb_source_gen: video timing generator with built-in test patterns.
//
// A horizontal counter (h_cnt) and a vertical counter (v_cnt) walk the full raster
// (sync, back porch, active, front porch). Every output is registered one clock after
// the counter state it describes, so all outputs stay mutually aligned.
//
// Ports:
//   Sys_Clock   in   pixel clock, rising edge
//   Reset       in   asynchronous, active-high reset
//   Enable      in   1 = timing runs, 0 = counters hold and outputs idle
//   Mode        in   pattern select (0 solid, 1 bars, 2 ramp, 3 checker), loaded at frame start
//   Solid_RGB   in   {R,G,B} used in solid mode, sampled every pixel
//   HSA, VSA    out  sync outputs, HS_POL / VS_POL when asserted
//   DE          out  data enable, high on active pixels
//   R, G, B     out  pixel colour, 0 outside the active area
//   Pixel_X     out  active column, 0 outside DE
//   Line_Y      out  active row, 0 outside DE
//   Frame_Start out  one-clock pulse for counter position 0/0
module rgb_source_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int unsigned CW       = 8,
  parameter int unsigned CHK_LOG2 = 4
) (
  input  logic            Sys_Clock,
  input  logic            Reset,
  input  logic            Enable,
  input  logic [1:0]      Mode,
  input  logic [3*CW-1:0] Solid_RGB,
  output logic            HSA,
  output logic            VSA,
  output logic            DE,
  output logic [CW-1:0]   R,
  output logic [CW-1:0]   G,
  output logic [CW-1:0]   B,
  output logic [15:0]     Pixel_X,
  output logic [15:0]     Line_Y,
  output logic            Frame_Start
);

  // Totals must fit in 16 bits (<= 65535).
  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST      = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC);
  localparam logic [15:0] H_ACT_START = 16'(H_SYNC + H_BP);
  localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] V_ACT_START = 16'(V_SYNC + V_BP);
  localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BP + V_ACTIVE);

  // Guard against a zero divisor when H_ACTIVE < 8.
  localparam int unsigned BAR_W_I = ((H_ACTIVE / 8) == 0) ? 1 : (H_ACTIVE / 8);
  localparam logic [15:0] BAR_W   = 16'(BAR_W_I);

  localparam logic [CW-1:0] ONES = {CW{1'b1}};

  logic [15:0] h_cnt_q, h_cnt_d;
  logic [15:0] v_cnt_q, v_cnt_d;
  logic [1:0]  mode_q, mode_d;

  logic        frame_origin;
  logic        active;
  logic [15:0] x, y;
  logic [15:0] bar_full;
  logic [2:0]  bar_idx;
  logic [2:0]  bar_rgb;
  logic [CW-1:0] ramp;
  logic        chk_on;

  logic            hsa_d, vsa_d, de_d, fs_d;
  logic [CW-1:0]   r_d, g_d, b_d;
  logic [15:0]     px_d, ly_d;

  assign frame_origin = (h_cnt_q == 16'd0) && (v_cnt_q == 16'd0);

  // Counter and mode register next state
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    mode_d  = mode_q;
    if (Enable) begin
      if (frame_origin) mode_d = Mode;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 16'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 16'd0 : v_cnt_q + 16'd1;
      end else begin
        h_cnt_d = h_cnt_q + 16'd1;
      end
    end
  end

  // Pattern generation from the current counter position
  always_comb begin
    active = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END) &&
             (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
    x        = h_cnt_q - H_ACT_START;
    y        = v_cnt_q - V_ACT_START;
    bar_full = x / BAR_W;
    // Remainder pixels beyond 8 full bars fold into the last (black) bar.
    bar_idx  = (bar_full > 16'd7) ? 3'd7 : bar_full[2:0];
    ramp     = CW'(x);
    chk_on   = x[CHK_LOG2] ^ y[CHK_LOG2];

    // Bar colours as {R,G,B} on/off bits
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111; // white
      3'd1:    bar_rgb = 3'b110; // yellow
      3'd2:    bar_rgb = 3'b011; // cyan
      3'd3:    bar_rgb = 3'b010; // green
      3'd4:    bar_rgb = 3'b101; // magenta
      3'd5:    bar_rgb = 3'b100; // red
      3'd6:    bar_rgb = 3'b001; // blue
      default: bar_rgb = 3'b000; // black
    endcase
  end

  // Output next state; Enable=0 idles everything
  always_comb begin
    hsa_d = ~HS_POL;
    vsa_d = ~VS_POL;
    de_d  = 1'b0;
    fs_d  = 1'b0;
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    px_d  = '0;
    ly_d  = '0;
    if (Enable) begin
      hsa_d = (h_cnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
      vsa_d = (v_cnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
      fs_d  = frame_origin;
      if (active) begin
        de_d = 1'b1;
        px_d = x;
        ly_d = y;
        // mode_q is already valid here: position 0/0 is never in the active area.
        case (mode_q)
          2'd0: begin
            r_d = Solid_RGB[3*CW-1:2*CW];
            g_d = Solid_RGB[2*CW-1:CW];
            b_d = Solid_RGB[CW-1:0];
          end
          2'd1: begin
            r_d = bar_rgb[2] ? ONES : '0;
            g_d = bar_rgb[1] ? ONES : '0;
            b_d = bar_rgb[0] ? ONES : '0;
          end
          2'd2: begin
            r_d = ramp;
            g_d = ramp;
            b_d = ramp;
          end
          default: begin
            r_d = chk_on ? ONES : '0;
            g_d = chk_on ? ONES : '0;
            b_d = chk_on ? ONES : '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Sys_Clock or posedge Reset) begin
    if (Reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      mode_q      <= 2'd0;
      HSA         <= ~HS_POL;
      VSA         <= ~VS_POL;
      DE          <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      Pixel_X     <= '0;
      Line_Y      <= '0;
      Frame_Start <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      mode_q      <= mode_d;
      HSA         <= hsa_d;
      VSA         <= vsa_d;
      DE          <= de_d;
      R           <= r_d;
      G           <= g_d;
      B           <= b_d;
      Pixel_X     <= px_d;
      Line_Y      <= ly_d;
      Frame_Start <= fs_d;
    end
  end

endmodule
